// File: rtl/watbulb_fifo_pkg.sv
// Shared types and width helpers for the watbulb parametrised FIFO.
package watbulb_fifo_pkg;

    typedef enum logic {RD_REG, RD_FWFT} rd_mode_e;

    function automatic int unsigned ptr_w(input int unsigned depth);
        return (depth <= 2) ? 1 : $clog2(depth);
    endfunction

    function automatic int unsigned lvl_w(input int unsigned depth);
        return $clog2(depth + 1);
    endfunction

    function automatic bit params_legal(input int unsigned depth, input int unsigned af,
                                        input int unsigned ae);
        return (depth >= 2) && (ae < af) && (af <= depth);
    endfunction

endpackage

// File: rtl/watbulb_fifo_wrap_ptr.sv
// Modulo-DEPTH pointer; wraps DEPTH-1 -> 0 explicitly so non-power-of-2 depths work.
module watbulb_fifo_wrap_ptr
    import watbulb_fifo_pkg::*;
#(
    parameter int unsigned DEPTH = 4,
    localparam int unsigned PW = ptr_w(DEPTH)
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          inc,
    output logic [PW-1:0] ptr
);

    localparam logic [PW-1:0] LAST = PW'(DEPTH - 1);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            ptr <= '0;
        end else if (inc) begin
            ptr <= (ptr == LAST) ? '0 : ptr + 1'b1;
        end
    end

endmodule

// File: rtl/watbulb_sync_fifo_v2.sv
// Parametrised single-clock FIFO with registered or first-word-fall-through read,
// threshold flags, fill level and sticky overflow/underflow.
module watbulb_sync_fifo_v2
    import watbulb_fifo_pkg::*;
#(
    parameter int unsigned DATA_WIDTH = 8,
    parameter int unsigned DEPTH      = 4,
    parameter int unsigned FWFT       = 0,
    parameter int unsigned AF_THRESH  = DEPTH - 1,
    parameter int unsigned AE_THRESH  = 1,
    localparam int unsigned LW = lvl_w(DEPTH)
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  wr_en,
    input  logic [DATA_WIDTH-1:0] wr_data,
    input  logic                  rd_en,
    output logic [DATA_WIDTH-1:0] rd_data,
    output logic                  rd_valid,
    output logic                  full,
    output logic                  empty,
    output logic                  almost_full,
    output logic                  almost_empty,
    output logic [LW-1:0]         level,
    output logic                  overflow,
    output logic                  underflow,
    input  logic                  clr_err
);

    localparam int unsigned   PW      = ptr_w(DEPTH);
    localparam rd_mode_e      RD_MODE = (FWFT != 0) ? RD_FWFT : RD_REG;
    localparam logic [LW-1:0] DEPTH_L = LW'(DEPTH);
    localparam logic [LW-1:0] AF_L    = LW'(AF_THRESH);
    localparam logic [LW-1:0] AE_L    = LW'(AE_THRESH);

    if (!params_legal(DEPTH, AF_THRESH, AE_THRESH)) begin : g_bad_params
        $error("watbulb_sync_fifo_v2: need DEPTH>=2 and AE_THRESH < AF_THRESH <= DEPTH");
    end

    logic [DATA_WIDTH-1:0] mem [DEPTH];
    logic [PW-1:0]         wr_ptr, rd_ptr;
    logic                  wr_acc, rd_acc;
    logic [LW-1:0]         level_q, level_d;
    logic                  full_q, empty_q, af_q, ae_q, ovf_q, unf_q;

    // Accept decisions look only at registered flags; no write-to-read bypass.
    assign wr_acc = wr_en & ~full_q;
    assign rd_acc = rd_en & ~empty_q;

    always_comb begin
        level_d = level_q + LW'(wr_acc) - LW'(rd_acc);
    end

    watbulb_fifo_wrap_ptr #(.DEPTH(DEPTH)) u_wr_ptr (
        .clk (clk),
        .rst (rst),
        .inc (wr_acc),
        .ptr (wr_ptr)
    );

    watbulb_fifo_wrap_ptr #(.DEPTH(DEPTH)) u_rd_ptr (
        .clk (clk),
        .rst (rst),
        .inc (rd_acc),
        .ptr (rd_ptr)
    );

    always_ff @(posedge clk) begin
        if (wr_acc) begin
            mem[wr_ptr] <= wr_data;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            level_q <= '0;
            full_q  <= 1'b0;
            empty_q <= 1'b1;
            af_q    <= 1'b0;
            ae_q    <= 1'b1;
            ovf_q   <= 1'b0;
            unf_q   <= 1'b0;
        end else begin
            level_q <= level_d;
            full_q  <= (level_d == DEPTH_L);
            empty_q <= (level_d == '0);
            af_q    <= (level_d >= AF_L);
            ae_q    <= (level_d <= AE_L);
            // A fresh error in the clearing cycle keeps the flag set.
            ovf_q   <= (ovf_q & ~clr_err) | (wr_en & full_q);
            unf_q   <= (unf_q & ~clr_err) | (rd_en & empty_q);
        end
    end

    if (RD_MODE == RD_REG) begin : g_rd_reg
        logic [DATA_WIDTH-1:0] rd_data_q;
        logic                  rd_valid_q;

        always_ff @(posedge clk or posedge rst) begin
            if (rst) begin
                rd_data_q  <= '0;
                rd_valid_q <= 1'b0;
            end else begin
                rd_valid_q <= rd_acc;
                if (rd_acc) begin
                    rd_data_q <= mem[rd_ptr];
                end
            end
        end

        assign rd_data  = rd_data_q;
        assign rd_valid = rd_valid_q;
    end else begin : g_rd_fwft
        // Masked while empty so the head reads as zero out of reset.
        assign rd_data  = empty_q ? '0 : mem[rd_ptr];
        assign rd_valid = ~empty_q;
    end

    assign level        = level_q;
    assign full         = full_q;
    assign empty        = empty_q;
    assign almost_full  = af_q;
    assign almost_empty = ae_q;
    assign overflow     = ovf_q;
    assign underflow    = unf_q;

endmodule

// File: tb/tb_watbulb_sync_fifo_v2.sv
// Bench: DEPTH=4 registered-read instance and DEPTH=3 FWFT instance against a queue model.
module tb_watbulb_sync_fifo_v2;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    // Instance A: DEPTH=4, FWFT=0
    logic       a_wr_en, a_rd_en, a_clr_err;
    logic [7:0] a_wr_data, a_rd_data;
    logic       a_rd_valid, a_full, a_empty, a_af, a_ae, a_ovf, a_unf;
    logic [2:0] a_level;

    // Instance B: DEPTH=3, FWFT=1
    logic       b_wr_en, b_rd_en, b_clr_err;
    logic [7:0] b_wr_data, b_rd_data;
    logic       b_rd_valid, b_full, b_empty, b_af, b_ae, b_ovf, b_unf;
    logic [1:0] b_level;

    watbulb_sync_fifo_v2 #(.DATA_WIDTH(8), .DEPTH(4), .FWFT(0)) u_dut_a (
        .clk          (clk),
        .rst          (rst),
        .wr_en        (a_wr_en),
        .wr_data      (a_wr_data),
        .rd_en        (a_rd_en),
        .rd_data      (a_rd_data),
        .rd_valid     (a_rd_valid),
        .full         (a_full),
        .empty        (a_empty),
        .almost_full  (a_af),
        .almost_empty (a_ae),
        .level        (a_level),
        .overflow     (a_ovf),
        .underflow    (a_unf),
        .clr_err      (a_clr_err)
    );

    watbulb_sync_fifo_v2 #(.DATA_WIDTH(8), .DEPTH(3), .FWFT(1)) u_dut_b (
        .clk          (clk),
        .rst          (rst),
        .wr_en        (b_wr_en),
        .wr_data      (b_wr_data),
        .rd_en        (b_rd_en),
        .rd_data      (b_rd_data),
        .rd_valid     (b_rd_valid),
        .full         (b_full),
        .empty        (b_empty),
        .almost_full  (b_af),
        .almost_empty (b_ae),
        .level        (b_level),
        .overflow     (b_ovf),
        .underflow    (b_unf),
        .clr_err      (b_clr_err)
    );

    typedef struct {
        logic       we;
        logic [7:0] wd;
        logic       re;
        logic       ce;
        logic [2:0] lvl;
        logic       full;
        logic       empty;
        logic       af;
        logic       ae;
        logic       ovf;
        logic       unf;
    } vec_t;

    localparam int NV = 11;
    vec_t vecs [NV];

    int checks = 0;
    int errors = 0;
    int m_lvl_a, m_lvl_b;
    logic [7:0] sb_a [$];
    logic [7:0] sb_b [$];
    logic [7:0] last_a;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", nm, act, exp);
        end
    endtask

    task automatic step_a(input logic we, input logic [7:0] wd, input logic re, input logic ce);
        logic wacc, racc;
        wacc = we && (m_lvl_a < 4);
        racc = re && (m_lvl_a > 0);
        a_wr_en = we; a_wr_data = wd; a_rd_en = re; a_clr_err = ce;
        @(posedge clk); #1;
        a_wr_en = 1'b0; a_rd_en = 1'b0; a_clr_err = 1'b0;
        if (wacc) sb_a.push_back(wd);
        if (racc) last_a = sb_a.pop_front();
        chk("a_rd_valid", 32'(a_rd_valid), 32'(racc));
        chk("a_rd_data", 32'(a_rd_data), 32'(last_a));
        m_lvl_a = m_lvl_a + int'(wacc) - int'(racc);
    endtask

    task automatic step_b(input logic we, input logic [7:0] wd, input logic re, input logic ce);
        logic wacc, racc;
        wacc = we && (m_lvl_b < 3);
        racc = re && (m_lvl_b > 0);
        b_wr_en = we; b_wr_data = wd; b_rd_en = re; b_clr_err = ce;
        @(posedge clk); #1;
        b_wr_en = 1'b0; b_rd_en = 1'b0; b_clr_err = 1'b0;
        if (racc) void'(sb_b.pop_front());
        if (wacc) sb_b.push_back(wd);
        m_lvl_b = m_lvl_b + int'(wacc) - int'(racc);
        chk("b_rd_valid", 32'(b_rd_valid), 32'(m_lvl_b > 0));
        if (m_lvl_b > 0) chk("b_rd_data", 32'(b_rd_data), 32'(sb_b[0]));
        chk("b_level", 32'(b_level), 32'(m_lvl_b));
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        //            we    wd     re    ce    lvl   full  empty af    ae    ovf   unf
        vecs[0]  = '{1'b1, 8'h11, 1'b0, 1'b0, 3'd1, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0};
        vecs[1]  = '{1'b1, 8'h22, 1'b0, 1'b0, 3'd2, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0};
        vecs[2]  = '{1'b1, 8'h33, 1'b0, 1'b0, 3'd3, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0};
        vecs[3]  = '{1'b1, 8'h44, 1'b0, 1'b0, 3'd4, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0};
        vecs[4]  = '{1'b1, 8'h55, 1'b0, 1'b0, 3'd4, 1'b1, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0};
        vecs[5]  = '{1'b0, 8'h00, 1'b1, 1'b0, 3'd3, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0};
        vecs[6]  = '{1'b0, 8'h00, 1'b1, 1'b0, 3'd2, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0};
        vecs[7]  = '{1'b0, 8'h00, 1'b1, 1'b0, 3'd1, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0};
        vecs[8]  = '{1'b0, 8'h00, 1'b1, 1'b0, 3'd0, 1'b0, 1'b1, 1'b0, 1'b1, 1'b1, 1'b0};
        vecs[9]  = '{1'b0, 8'h00, 1'b1, 1'b0, 3'd0, 1'b0, 1'b1, 1'b0, 1'b1, 1'b1, 1'b1};
        vecs[10] = '{1'b0, 8'h00, 1'b0, 1'b1, 3'd0, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0};

        rst = 1'b1;
        a_wr_en = 1'b0; a_wr_data = '0; a_rd_en = 1'b0; a_clr_err = 1'b0;
        b_wr_en = 1'b0; b_wr_data = '0; b_rd_en = 1'b0; b_clr_err = 1'b0;
        m_lvl_a = 0; m_lvl_b = 0; last_a = '0;
        repeat (2) @(posedge clk);
        #1 rst = 1'b0;
        @(posedge clk); #1;

        chk("rst a_level", 32'(a_level), 32'(0));
        chk("rst a_empty", 32'(a_empty), 32'(1));
        chk("rst a_full", 32'(a_full), 32'(0));
        chk("rst a_af", 32'(a_af), 32'(0));
        chk("rst a_ae", 32'(a_ae), 32'(1));
        chk("rst a_ovf", 32'(a_ovf), 32'(0));
        chk("rst a_unf", 32'(a_unf), 32'(0));
        chk("rst a_rd_data", 32'(a_rd_data), 32'(0));
        chk("rst a_rd_valid", 32'(a_rd_valid), 32'(0));
        chk("rst b_empty", 32'(b_empty), 32'(1));
        chk("rst b_rd_valid", 32'(b_rd_valid), 32'(0));

        // Fill, overflow, drain, underflow, clear on the registered-read instance
        for (int i = 0; i < NV; i++) begin
            step_a(vecs[i].we, vecs[i].wd, vecs[i].re, vecs[i].ce);
            chk($sformatf("vec%0d level", i), 32'(a_level), 32'(vecs[i].lvl));
            chk($sformatf("vec%0d full", i), 32'(a_full), 32'(vecs[i].full));
            chk($sformatf("vec%0d empty", i), 32'(a_empty), 32'(vecs[i].empty));
            chk($sformatf("vec%0d almost_full", i), 32'(a_af), 32'(vecs[i].af));
            chk($sformatf("vec%0d almost_empty", i), 32'(a_ae), 32'(vecs[i].ae));
            chk($sformatf("vec%0d overflow", i), 32'(a_ovf), 32'(vecs[i].ovf));
            chk($sformatf("vec%0d underflow", i), 32'(a_unf), 32'(vecs[i].unf));
        end

        // Simultaneous read+write at level 2 across several pointer wraps
        step_a(1'b1, 8'hA0, 1'b0, 1'b0);
        step_a(1'b1, 8'hA1, 1'b0, 1'b0);
        for (int i = 0; i < 10; i++) begin
            step_a(1'b1, 8'(8'hB0 + i), 1'b1, 1'b0);
            chk("simul level", 32'(a_level), 32'(2));
            chk("simul ovf", 32'(a_ovf), 32'(0));
        end
        step_a(1'b0, 8'h00, 1'b1, 1'b0);
        step_a(1'b0, 8'h00, 1'b1, 1'b0);
        chk("simul drained empty", 32'(a_empty), 32'(1));
        chk("simul unf", 32'(a_unf), 32'(0));

        // FWFT instance: fall-through timing and pop
        step_b(1'b1, 8'hA5, 1'b0, 1'b0);
        chk("fwft a5 empty", 32'(b_empty), 32'(0));
        step_b(1'b0, 8'h00, 1'b1, 1'b0);
        chk("fwft pop empty", 32'(b_empty), 32'(1));

        for (int r = 0; r < 7; r++) begin
            for (int i = 0; i < 3; i++) step_b(1'b1, 8'(r * 16 + i + 1), 1'b0, 1'b0);
            chk("fwft round full", 32'(b_full), 32'(1));
            chk("fwft round af", 32'(b_af), 32'(1));
            for (int i = 0; i < 3; i++) step_b(1'b0, 8'h00, 1'b1, 1'b0);
            chk("fwft round empty", 32'(b_empty), 32'(1));
            chk("fwft round ae", 32'(b_ae), 32'(1));
        end

        // Sticky error flags and clear priority
        for (int i = 0; i < 3; i++) step_b(1'b1, 8'(8'hC0 + i), 1'b0, 1'b0);
        step_b(1'b1, 8'hEE, 1'b0, 1'b0);
        chk("ovf set", 32'(b_ovf), 32'(1));
        step_b(1'b0, 8'h00, 1'b0, 1'b1);
        chk("ovf cleared", 32'(b_ovf), 32'(0));
        step_b(1'b1, 8'hEF, 1'b0, 1'b1);
        chk("ovf set beats clear", 32'(b_ovf), 32'(1));
        for (int i = 0; i < 3; i++) step_b(1'b0, 8'h00, 1'b1, 1'b0);
        step_b(1'b0, 8'h00, 1'b1, 1'b0);
        chk("b unf set", 32'(b_unf), 32'(1));
        step_b(1'b0, 8'h00, 1'b0, 1'b1);
        chk("b clr ovf", 32'(b_ovf), 32'(0));
        chk("b clr unf", 32'(b_unf), 32'(0));

        // Asynchronous reset between edges at level 3
        step_a(1'b1, 8'hC1, 1'b0, 1'b0);
        step_a(1'b1, 8'hC2, 1'b0, 1'b0);
        step_a(1'b1, 8'hC3, 1'b0, 1'b0);
        step_a(1'b0, 8'h00, 1'b1, 1'b0);
        step_a(1'b1, 8'hC4, 1'b0, 1'b0);
        chk("pre-rst level", 32'(a_level), 32'(3));
        #3 rst = 1'b1;
        #1;
        chk("async rst level", 32'(a_level), 32'(0));
        chk("async rst empty", 32'(a_empty), 32'(1));
        chk("async rst full", 32'(a_full), 32'(0));
        chk("async rst af", 32'(a_af), 32'(0));
        chk("async rst ae", 32'(a_ae), 32'(1));
        chk("async rst rd_data", 32'(a_rd_data), 32'(0));
        chk("async rst rd_valid", 32'(a_rd_valid), 32'(0));
        #2 rst = 1'b0;
        m_lvl_a = 0; sb_a.delete(); last_a = '0;
        m_lvl_b = 0; sb_b.delete();
        @(posedge clk); #1;
        step_a(1'b0, 8'h00, 1'b1, 1'b0);
        chk("post-rst read rejected unf", 32'(a_unf), 32'(1));
        chk("post-rst level", 32'(a_level), 32'(0));

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/watbulb_sync_fifo_v2.md
Name: watbulb_sync_fifo_v2

Overview:
- Parametrised single-clock FIFO; successor to the fixed 6-bit/depth-3 Tiny Tapeout FIFO.
- Adds arbitrary width and depth, non-power-of-2 wrap, simultaneous read+write, and selectable read mode (registered or first-word-fall-through).
- Adds almost-full/almost-empty thresholds, a fill-level output, and sticky overflow/underflow error flags.
- Instantiated under a thin tt_um_* wrapper or used standalone as a buffering core.

Parameters:
- DATA_WIDTH, 8: payload bits, >=1.
- DEPTH, 4: number of entries, >=2, any integer (not restricted to powers of 2).
- FWFT, 0: 0 = registered read (1-cycle latency); 1 = first-word-fall-through.
- AF_THRESH, DEPTH-1: almost_full asserted when level >= AF_THRESH.
- AE_THRESH, 1: almost_empty asserted when level <= AE_THRESH.

Ports:
- clk  in  1  clock; one clock, all logic on rising edge.
- rst  in  1  reset; asynchronous and active-high.
- wr_en  in  1  push request.
- wr_data  in  DATA_WIDTH  push payload.
- rd_en  in  1  pop request.
- rd_data  out  DATA_WIDTH  pop payload.
- rd_valid  out  1  rd_data holds valid output data (meaning depends on FWFT).
- full  out  1  level == DEPTH.
- empty  out  1  level == 0.
- almost_full  out  1  level >= AF_THRESH.
- almost_empty  out  1  level <= AE_THRESH.
- level  out  LW  entry count; LW = $clog2(DEPTH+1).
- overflow  out  1  sticky: a write was rejected.
- underflow  out  1  sticky: a read was rejected.
- clr_err  in  1  synchronous clear of overflow/underflow.

Behaviour:
- Reset (async assert, sync release): pointers=0, level=0, empty=1, full=0, almost_full=0, almost_empty=(0<=AE_THRESH), overflow=0, underflow=0, rd_data=0, rd_valid=0. Storage array is not reset.
- Accept rules:
  - wr_acc = wr_en & ~full.
  - rd_acc = rd_en & ~empty.
  - Both are decided from registered flags only; there is no combinational wr-to-rd bypass.
- Same-cycle events:
  - wr_acc & rd_acc: both pointers advance and level is unchanged.
  - Write to a full FIFO is rejected even if a read is accepted in the same cycle.
  - Read from an empty FIFO is rejected even if a write is accepted in the same cycle.
- Level arithmetic:
  - level_next = level + wr_acc - rd_acc, computed in LW bits.
  - level can never exceed DEPTH or go below 0.
- Flags (full, empty, almost_*): registered, derived from level_next, so they are valid in the cycle after the event.
- Pointers: width $clog2(DEPTH), max 1. Increment with explicit wrap DEPTH-1 -> 0 (never a natural binary wrap).
- FWFT=0:
  - On rd_acc, rd_data <= mem[rd_ptr] at the clock edge; rd_valid pulses high for exactly that following cycle.
  - rd_data holds its value otherwise.
- FWFT=1:
  - rd_data = mem[rd_ptr] (combinational from storage), rd_valid = ~empty.
  - rd_en acts as acknowledge/pop.
  - A word written into an empty FIFO appears on rd_data one cycle after the write edge.
- overflow: set on wr_en & full; underflow: set on rd_en & empty.
  - clr_err clears both.
  - A set event in the same cycle as clr_err wins (flag stays 1).
- Reset mid-operation: state returns to the reset values immediately; no partial write commits.

Decomposition:
- Package watbulb_fifo_pkg:
  - typedef enum {RD_REG, RD_FWFT} rd_mode_e.
  - Functions ptr_w(depth) and lvl_w(depth).
  - Parameter-legality checks (DEPTH>=2, AE_THRESH < AF_THRESH <= DEPTH) via elaboration $error.
- One sub-module, watbulb_fifo_wrap_ptr:
  - Parametrised modulo-DEPTH pointer with inc input.
  - Instantiated twice (write and read pointers).

Test Plan:
- DEPTH=4, FWFT=0: write 0x11,0x22,0x33,0x44 -> full=1 and level=4 after the 4th edge, almost_full=1 at level 3; 5th write -> overflow=1, contents unchanged.
- Drain: 4 reads -> rd_data 0x11,0x22,0x33,0x44, each with a 1-cycle rd_valid pulse; empty=1 after the last; extra read -> underflow=1, rd_data holds 0x44.
- Simultaneous: at level 2, wr_en=rd_en=1 for 10 cycles with incrementing data -> level stays 2, output order preserved, pointers wrap 3->0 without error.
- DEPTH=3 (non-power-of-2), FWFT=1: write 0xA5 to empty -> rd_valid=1 and rd_data=0xA5 the next cycle; pop -> empty=1; 7 fill/drain rounds -> ordering correct across the wrap.
- Errors: raise overflow, then pulse clr_err alone -> overflow=0; clr_err in the same cycle as wr_en&full -> overflow stays 1.
- Reset: assert rst asynchronously between edges at level 3 -> outputs take reset values before the next edge; the first read after release is rejected (underflow=1).
